// File: rtl/tia_frame_decoder_if.sv
// TIA video stream into the frame decoder, plus the recovered pixel/frame
// geometry coming back out. The master side is the TIA/stream source.
interface tia_frame_decoder_if;
  logic       pix_ce;
  logic [3:0] col;
  logic [2:0] lum;
  logic       hsync;
  logic       hblank;
  logic       vsync;
  logic       vblank;

  logic [6:0] pix_out;
  logic       pix_valid;
  logic [7:0] x;
  logic [8:0] y;
  logic       frame_start;
  logic [8:0] lines_per_frame;
  logic       locked;
  logic       pal;
  logic       timeout;

  modport master (
    output pix_ce, col, lum, hsync, hblank, vsync, vblank,
    input  pix_out, pix_valid, x, y, frame_start, lines_per_frame, locked, pal, timeout
  );

  modport slave (
    input  pix_ce, col, lum, hsync, hblank, vsync, vblank,
    output pix_out, pix_valid, x, y, frame_start, lines_per_frame, locked, pal, timeout
  );
endinterface

// File: rtl/tia_frame_decoder.sv
// Recovers pixel x/y, frame length, NTSC/PAL class and lock from the raw TIA
// colour-clock stream. All state advances only on pix_ce samples.
module tia_frame_decoder #(
  parameter int MIN_LINES     = 200,
  parameter int MAX_LINES     = 320,
  parameter int PAL_LINES     = 290,
  parameter int TIMEOUT_LINES = 400,
  parameter int JITTER        = 2
) (
  input logic              clk,
  input logic              reset,
  tia_frame_decoder_if.slave tia
);

  localparam logic [8:0] MIN_L    = 9'(MIN_LINES);
  localparam logic [8:0] MAX_L    = 9'(MAX_LINES);
  localparam logic [8:0] PAL_L    = 9'(PAL_LINES);
  localparam logic [8:0] TMO_LAST = 9'(TIMEOUT_LINES - 1);
  localparam logic [8:0] JIT      = 9'(JITTER);
  localparam logic [8:0] LINE_SAT = 9'd511;
  localparam logic [7:0] X_LAST   = 8'd159;

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  state_t     state, state_nxt;
  logic [8:0] ref_q, ref_nxt;
  logic       pal_q, pal_nxt;
  logic       locked_o;

  logic       hsync_q, hblank_q, vsync_q;
  logic       hs_rise, hb_fall, vs_rise, active, visible;
  logic       tmo_evt, meas, in_range, jit_ok;
  logic [8:0] diff;

  logic [6:0] pix_q;
  logic       pix_vld_q;
  logic [7:0] x_q;
  logic [8:0] line_cnt;
  logic       fs_q, meas_ok, tmo_q;
  logic [8:0] lpf_q;

  // Edge history only moves on sampled colour clocks.
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync_q  <= 1'b0;
      hblank_q <= 1'b0;
      vsync_q  <= 1'b0;
    end else if (tia.pix_ce) begin
      hsync_q  <= tia.hsync;
      hblank_q <= tia.hblank;
      vsync_q  <= tia.vsync;
    end
  end

  assign hs_rise  = tia.pix_ce & tia.hsync & ~hsync_q;
  assign hb_fall  = tia.pix_ce & ~tia.hblank & hblank_q;
  assign vs_rise  = tia.pix_ce & tia.vsync & ~vsync_q;
  assign active   = tia.pix_ce & ~tia.hblank;
  assign visible  = active & ~tia.vblank;
  // A vsync rise on the same sample swallows the line, so it can't time out.
  assign tmo_evt  = hs_rise & ~vs_rise & (line_cnt == TMO_LAST);
  assign meas     = vs_rise & meas_ok;
  assign in_range = (line_cnt >= MIN_L) && (line_cnt <= MAX_L);
  assign diff     = (line_cnt >= ref_q) ? (line_cnt - ref_q) : (ref_q - line_cnt);
  assign jit_ok   = (diff <= JIT);

  // Pixel path: x is the column of the pixel being presented.
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_q     <= '0;
      pix_vld_q <= 1'b0;
      x_q       <= '0;
    end else begin
      pix_vld_q <= visible;
      if (visible)
        pix_q <= {tia.col, tia.lum};
      if (active)
        x_q <= hb_fall ? 8'd0 : ((x_q == X_LAST) ? X_LAST : x_q + 8'd1);
    end
  end

  // Line counting, frame starts (real or synthesized) and length measurement.
  always_ff @(posedge clk) begin
    if (reset) begin
      line_cnt <= '0;
      fs_q     <= 1'b0;
      meas_ok  <= 1'b0;
      tmo_q    <= 1'b0;
      lpf_q    <= '0;
    end else begin
      fs_q <= vs_rise | tmo_evt;
      if (vs_rise) begin
        line_cnt <= '0;
        tmo_q    <= 1'b0;
        meas_ok  <= 1'b1;
        if (meas_ok && in_range)
          lpf_q <= line_cnt;
      end else if (tmo_evt) begin
        line_cnt <= '0;
        tmo_q    <= 1'b1;
        meas_ok  <= 1'b0;
      end else if (hs_rise && line_cnt != LINE_SAT) begin
        line_cnt <= line_cnt + 9'd1;
      end
    end
  end

  // Lock FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SEARCH;
      ref_q <= '0;
      pal_q <= 1'b0;
    end else begin
      state <= state_nxt;
      ref_q <= ref_nxt;
      pal_q <= pal_nxt;
    end
  end

  // Lock FSM: next state, advanced only by a measurement or a timeout
  always_comb begin
    state_nxt = state;
    ref_nxt   = ref_q;
    pal_nxt   = pal_q;
    if (tmo_evt) begin
      state_nxt = SEARCH;
    end else if (meas) begin
      case (state)
        SEARCH: begin
          if (in_range) begin
            state_nxt = TRACK;
            ref_nxt   = line_cnt;
          end
        end
        TRACK: begin
          if (line_cnt == ref_q) begin
            state_nxt = LOCKED;
            pal_nxt   = (ref_q >= PAL_L);
          end else if (in_range) begin
            ref_nxt = line_cnt;
          end else begin
            state_nxt = SEARCH;
          end
        end
        LOCKED: begin
          // Small wobble keeps the lock and the original reference.
          if (!jit_ok) begin
            if (in_range) begin
              state_nxt = TRACK;
              ref_nxt   = line_cnt;
            end else begin
              state_nxt = SEARCH;
            end
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end
  end

  // Lock FSM: outputs
  always_comb begin
    locked_o = (state == LOCKED);
  end

  assign tia.pix_out         = pix_q;
  assign tia.pix_valid       = pix_vld_q;
  assign tia.x               = x_q;
  assign tia.y               = line_cnt;
  assign tia.frame_start     = fs_q;
  assign tia.lines_per_frame = lpf_q;
  assign tia.locked          = locked_o;
  assign tia.pal             = pal_q;
  assign tia.timeout         = tmo_q;

endmodule
